// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Pointer helpers shared by the read-side and write-side controls of the
// asynchronous FIFO.
//   ADDR_W_DEFAULT : default RAM address width (FIFO depth = 2**ADDR_W).
//   bin2gray()     : binary to reflected Gray code.
//   gray2bin()     : reflected Gray code to binary.
// The functions work on a 32-bit container. Callers zero-extend narrower
// pointers on the way in and truncate the result on the way out. Zero
// upper bits stay zero in both directions, so one pair of functions covers
// every pointer width.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int ADDR_W_DEFAULT = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    // Each binary bit is the XOR of all Gray bits from the MSB down to that bit.
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// -----------------------------------------------------------------------------
// sync_w2r
// Multi-flop synchroniser for a Gray-coded pointer that crosses into the
// clk domain. The write side uses the same module, mirrored, as sync_r2w.
//   clk   : destination-domain clock
//   reset : asynchronous, active-high; clears every stage to 0
//   d     : pointer from the source domain (asynchronous to clk)
//   q     : pointer after STAGES flops
// Only one bit of a Gray pointer changes per step, so a flop that resolves
// the wrong way still yields either the old value or the new value.
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module sync_w2r #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: sequential state uses non-blocking (<=) so that every stage samples
  // the value its neighbour held before the edge. With blocking assignments,
  // d would fall through the whole chain in a single cycle.
  // NOTE: this is a shift chain, not a RAM, so every stage is reset. The
  // empty flag must not see stale pointer bits after a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/read_control_param.sv
// -----------------------------------------------------------------------------
// read_control_param
// Read-side pointer and flag controller for the asynchronous FIFO. Runs
// entirely in the rd_clk domain, between the RAM read port and the consumer.
//   rd_clk      : read-domain clock
//   reset       : asynchronous, active-high
//   rd_en       : consumer read request
//   wr_ptr_gray : Gray write pointer from the write domain (unsynchronised)
//   rd_addr     : RAM read address (low ADDR_W bits of rd_ptr_bin)
//   rd_ptr_bin  : binary read pointer; MSB is the wrap bit
//   rd_ptr_gray : registered Gray read pointer, exported to the write domain
//   f_empty     : FIFO empty (registered)
//   f_aempty    : occupancy <= AEMPTY_THRESH (registered)
//   rd_count    : occupancy seen from the read side, 0..2**ADDR_W
//   rd_valid    : one cycle after an accepted read (RAM data valid)
//   underflow   : one-cycle pulse for a read rejected because the FIFO is empty
// The write pointer becomes visible SYNC_STAGES+1 edges after it changes.
// This makes the flags pessimistic: empty may persist for a few cycles too
// long, but it never deasserts falsely.
// -----------------------------------------------------------------------------
module read_control_param
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_bin,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              f_empty,
  output logic              f_aempty,
  output logic [ADDR_W:0]   rd_count,
  output logic              rd_valid,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AEMPTY_LIMIT = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] wq_gray;
  logic [PTR_W-1:0] wq_bin;
  logic             accept;
  logic [PTR_W-1:0] rd_bin_next;
  logic [PTR_W-1:0] rd_gray_next;
  logic [PTR_W-1:0] occupancy_next;

  sync_w2r #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_w2r (
    .clk   (rd_clk),
    .reset (reset),
    .d     (wr_ptr_gray),
    .q     (wq_gray)
  );

  // NOTE: every signal assigned in this block gets a value on every pass.
  // That keeps the block purely combinational, so no latch is inferred.
  always_comb begin
    accept         = rd_en & ~f_empty;
    rd_bin_next    = rd_ptr_bin + PTR_W'(accept);
    rd_gray_next   = PTR_W'(bin2gray(32'(rd_bin_next)));
    wq_bin         = PTR_W'(gray2bin(32'(wq_gray)));
    // Modulo-2**PTR_W difference. The wrap bit lets a full FIFO
    // (2**ADDR_W entries) be told apart from an empty one.
    occupancy_next = wq_bin - rd_bin_next;
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_bin  <= '0;
      rd_ptr_gray <= '0;
      f_empty     <= 1'b1;
      f_aempty    <= 1'b1;
      rd_count    <= '0;
      rd_valid    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      rd_ptr_bin  <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      f_empty     <= (rd_gray_next == wq_gray);
      f_aempty    <= (occupancy_next <= AEMPTY_LIMIT);
      rd_count    <= occupancy_next;
      rd_valid    <= accept;
      // A rejected read leaves the pointers alone: accept is 0 in that case.
      underflow   <= rd_en & f_empty;
    end
  end

  assign rd_addr = rd_ptr_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_read_control_param.sv
// -----------------------------------------------------------------------------
// tb_read_control_param
// Directed, table-driven bench for read_control_param at ADDR_W=3,
// SYNC_STAGES=2, AEMPTY_THRESH=1. Each table row gives the inputs for one
// rd_clk cycle and the outputs expected after that edge. Hand-written
// sequences cover asynchronous reset (at start and mid-drain) and rd_en
// held during reset.
// -----------------------------------------------------------------------------
module tb_read_control_param;

  localparam int ADDR_W = 3;

  logic              rd_clk;
  logic              reset;
  logic              rd_en;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_ptr_bin;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              f_empty;
  logic              f_aempty;
  logic [ADDR_W:0]   rd_count;
  logic              rd_valid;
  logic              underflow;

  int n_cmp = 0;
  int n_err = 0;

  read_control_param #(
    .ADDR_W        (3),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (1)
  ) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_addr     (rd_addr),
    .rd_ptr_bin  (rd_ptr_bin),
    .rd_ptr_gray (rd_ptr_gray),
    .f_empty     (f_empty),
    .f_aempty    (f_aempty),
    .rd_count    (rd_count),
    .rd_valid    (rd_valid),
    .underflow   (underflow)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic       rd_en;
    logic [3:0] wr_g;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       empty;
    logic       aempty;
    logic [3:0] count;
    logic       valid;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge; sample 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  function automatic vec_t mk(logic en, logic [3:0] wg, logic [3:0] b, logic [3:0] g,
                              logic e, logic ae, logic [3:0] c, logic v, logic u);
    vec_t r;
    r.rd_en = en; r.wr_g = wg; r.bin = b; r.gray = g; r.empty = e;
    r.aempty = ae; r.count = c; r.valid = v; r.uf = u;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, ".rd_ptr_bin"},  32'(rd_ptr_bin),  32'h0);
    check({tag, ".rd_ptr_gray"}, 32'(rd_ptr_gray), 32'h0);
    check({tag, ".f_empty"},     32'(f_empty),     32'h1);
    check({tag, ".f_aempty"},    32'(f_aempty),    32'h1);
    check({tag, ".rd_count"},    32'(rd_count),    32'h0);
    check({tag, ".rd_valid"},    32'(rd_valid),    32'h0);
    check({tag, ".underflow"},   32'(underflow),   32'h0);
  endtask

  initial begin
    // Fields: rd_en, wr_ptr_gray, bin, gray, empty, aempty, count, valid, underflow
    // Write arrival: pointer 4 (Gray 0110) becomes visible on the 3rd edge.
    vecs.push_back(mk(0, 4'b0110, 4'd0,  4'b0000, 1, 1, 4'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'd0,  4'b0000, 1, 1, 4'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'd0,  4'b0000, 0, 0, 4'd4, 0, 0));
    // Drain four entries.
    vecs.push_back(mk(1, 4'b0110, 4'd1,  4'b0001, 0, 0, 4'd3, 1, 0));
    vecs.push_back(mk(1, 4'b0110, 4'd2,  4'b0011, 0, 0, 4'd2, 1, 0));
    vecs.push_back(mk(1, 4'b0110, 4'd3,  4'b0010, 0, 1, 4'd1, 1, 0));
    vecs.push_back(mk(1, 4'b0110, 4'd4,  4'b0110, 1, 1, 4'd0, 1, 0));
    // Underflow: two rejected reads, pointer holds at 4.
    vecs.push_back(mk(1, 4'b0110, 4'd4,  4'b0110, 1, 1, 4'd0, 0, 1));
    vecs.push_back(mk(1, 4'b0110, 4'd4,  4'b0110, 1, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 4'b0110, 4'd4,  4'b0110, 1, 1, 4'd0, 0, 0));
    // Wrap: write pointer 12 (Gray 1010), full-depth count of 8.
    vecs.push_back(mk(0, 4'b1010, 4'd4,  4'b0110, 1, 1, 4'd0, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'd4,  4'b0110, 1, 1, 4'd0, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'd4,  4'b0110, 0, 0, 4'd8, 0, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd5,  4'b0111, 0, 0, 4'd7, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd6,  4'b0101, 0, 0, 4'd6, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd7,  4'b0100, 0, 0, 4'd5, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd8,  4'b1100, 0, 0, 4'd4, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd9,  4'b1101, 0, 0, 4'd3, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd10, 4'b1111, 0, 0, 4'd2, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd11, 4'b1110, 0, 1, 4'd1, 1, 0));
    vecs.push_back(mk(1, 4'b1010, 4'd12, 4'b1010, 1, 1, 4'd0, 1, 0));
    vecs.push_back(mk(0, 4'b1010, 4'd12, 4'b1010, 1, 1, 4'd0, 0, 0));

    // Asynchronous reset at start: asserted mid-cycle, before any clock edge.
    reset       = 1'b0;
    rd_en       = 1'b0;
    wr_ptr_gray = 4'b0000;
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset_start");
    step();
    step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      if (vecs[i].rd_en) begin
        // rd_addr presented to the RAM for this read is the pre-edge pointer.
        check({tag, ".rd_addr_pre"}, 32'(rd_addr), 32'(rd_ptr_bin_expected_prev(i)));
      end
      rd_en       = vecs[i].rd_en;
      wr_ptr_gray = vecs[i].wr_g;
      step();
      check({tag, ".rd_ptr_bin"},  32'(rd_ptr_bin),  32'(vecs[i].bin));
      check({tag, ".rd_addr"},     32'(rd_addr),     32'(vecs[i].bin[2:0]));
      check({tag, ".rd_ptr_gray"}, 32'(rd_ptr_gray), 32'(vecs[i].gray));
      check({tag, ".f_empty"},     32'(f_empty),     32'(vecs[i].empty));
      check({tag, ".f_aempty"},    32'(f_aempty),    32'(vecs[i].aempty));
      check({tag, ".rd_count"},    32'(rd_count),    32'(vecs[i].count));
      check({tag, ".rd_valid"},    32'(rd_valid),    32'(vecs[i].valid));
      check({tag, ".underflow"},   32'(underflow),   32'(vecs[i].uf));
    end

    // Reset mid-drain. Pointer is at 12; write pointer 15 (Gray 1000) gives count 3.
    rd_en       = 1'b0;
    wr_ptr_gray = 4'b1000;
    step(); step(); step();
    check("middrain.rd_count", 32'(rd_count), 32'd3);
    check("middrain.f_empty",  32'(f_empty),  32'd0);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset_mid");

    // rd_en held while reset is asserted must be ignored.
    rd_en       = 1'b1;
    wr_ptr_gray = 4'b0000;
    step(); step();
    check_reset_values("rd_en_in_reset");
    reset = 1'b0;
    rd_en = 1'b0;

    // After release, empty holds while the synchronised pointer is still 0000.
    step(); step(); step();
    check("post_reset.f_empty",  32'(f_empty),  32'd1);
    check("post_reset.rd_count", 32'(rd_count), 32'd0);
    wr_ptr_gray = 4'b0001;
    step(); step();
    check("post_reset.sync_hold_empty", 32'(f_empty), 32'd1);
    step();
    check("post_reset.f_empty_clear", 32'(f_empty),  32'd0);
    check("post_reset.rd_count_1",    32'(rd_count), 32'd1);
    check("post_reset.f_aempty",      32'(f_aempty), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_reset.rd_valid",    32'(rd_valid),    32'd1);
    check("post_reset.rd_ptr_bin",  32'(rd_ptr_bin),  32'd1);
    check("post_reset.rd_ptr_gray", 32'(rd_ptr_gray), 32'b0001);
    check("post_reset.f_empty_end", 32'(f_empty),     32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Pointer expected before row i: the previous row's pointer, or 0 for the first row.
  function automatic logic [3:0] rd_ptr_bin_expected_prev(int i);
    return (i == 0) ? 4'd0 : {1'b0, vecs[i-1].bin[2:0]};
  endfunction

endmodule

// File: doc/read_control_param.md
Name: read_control_param

Overview:
Parametrised read-side pointer/flag controller for the team's asynchronous FIFO. It generalises the fixed 8-deep read control to configurable depth (2^ADDR_W) and synchroniser length. It adds in-block write-pointer synchronisation, registered empty and almost-empty flags, an occupancy count, a read-valid strobe and underflow detection. It sits in the rd_clk domain between the dual-port RAM read port and the consumer.

Parameters:
ADDR_W, 3, RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits (MSB = wrap bit).
SYNC_STAGES, 2, number of flops synchronising wr_ptr_gray into rd_clk (minimum 2).
AEMPTY_THRESH, 1, f_aempty asserts when occupancy <= this value (range 0..2^ADDR_W-1).

Ports:
rd_clk  in  1  read-domain clock; the block's only clock.
reset  in  1  asynchronous, active-high reset.
rd_en  in  1  consumer read request.
wr_ptr_gray  in  ADDR_W+1  Gray-coded write pointer from the write domain (unsynchronised).
rd_addr  out  ADDR_W  RAM read address = rd_ptr_bin[ADDR_W-1:0].
rd_ptr_bin  out  ADDR_W+1  binary read pointer; MSB is the wrap bit.
rd_ptr_gray  out  ADDR_W+1  Gray-coded read pointer, registered, exported to the write domain.
f_empty  out  1  FIFO empty (registered).
f_aempty  out  1  almost empty (registered).
rd_count  out  ADDR_W+1  occupancy as seen from the read domain, range 0..2^ADDR_W.
rd_valid  out  1  one-cycle strobe, one cycle after an accepted read (RAM data valid).
underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge): rd_ptr_bin=0, rd_ptr_gray=0, all sync stages=0, f_empty=1, f_aempty=1, rd_count=0, rd_valid=0, underflow=0.
- Accept: accept = rd_en & ~f_empty. rd_bin_next = rd_ptr_bin + accept, modulo 2^(ADDR_W+1), wrapping from all-ones to 0.
- Pointer update: on each rd_clk edge, rd_ptr_bin <= rd_bin_next and rd_ptr_gray <= bin2gray(rd_bin_next). Only one Gray bit changes per increment.
- Synchroniser: wr_ptr_gray passes through SYNC_STAGES flops to give wq_gray; wq_bin = gray2bin(wq_gray).
- Empty: f_empty <= (bin2gray(rd_bin_next) == wq_gray). A write becomes visible after SYNC_STAGES+1 rd_clk edges (3 at default).
- Count: rd_count <= (wq_bin - rd_bin_next) mod 2^(ADDR_W+1).
- Almost empty: f_aempty <= ((wq_bin - rd_bin_next) mod 2^(ADDR_W+1)) <= AEMPTY_THRESH.
- Read strobe: rd_valid <= accept. Read latency is 1 cycle.
- Underflow: underflow <= rd_en & f_empty. Pointers and flags do not change on an underflow.
- Simultaneous read and write-pointer change: the read is evaluated against the current f_empty. The new write pointer only affects flags after synchronisation. The block is pessimistic and never falsely deasserts empty.
- Wrap: the full-depth count 2^ADDR_W is reported correctly. The MSB distinguishes full from empty when the address bits are equal.
- rd_en while reset is asserted is ignored.
- No state machine beyond the pointer register. The control path has no combinational path from input to output.

Decomposition:
- Package fifo_ptr_pkg holds the bin2gray and gray2bin functions (width-generic, or sized from ADDR_W) and the default ADDR_W constant. The same package is shared with the write-control block.
- One sub-module, sync_w2r: SYNC_STAGES-deep, ADDR_W+1-wide flop chain with an async active-high reset to 0. It is reused mirrored as sync_r2w in the write side.

Test Plan:
All scenarios use ADDR_W=3, SYNC_STAGES=2, AEMPTY_THRESH=1.
1. Reset: assert reset mid-cycle with no clock edge -> rd_ptr_gray=0000, rd_count=0, f_empty=1, f_aempty=1, rd_valid=0 immediately.
2. Write arrival: from reset, set wr_ptr_gray=0110 (bin 4) -> f_empty=1 for 2 edges, then f_empty=0, rd_count=4, f_aempty=0 on the 3rd edge.
3. Drain: hold rd_en 4 cycles -> rd_addr=0,1,2,3; rd_valid high on the following 4 cycles; f_aempty=1 after the 3rd accept; f_empty=1 and rd_ptr_gray=0110 after the 4th.
4. Underflow: rd_en=1 for 2 cycles while empty -> underflow high 2 cycles; rd_ptr_bin stays 4; rd_valid=0.
5. Wrap: with rd_ptr_bin=4, set wr_ptr_gray=1010 (bin 12) -> rd_count=8. Read 8 -> rd_addr=4,5,6,7,0,1,2,3; rd_ptr_gray passes 1100 at bin 8 (MSB toggles); ends at 1010 with f_empty=1.
6. Reset mid-drain: with rd_count=3, assert reset asynchronously -> all outputs return to reset values before the next edge; after release, f_empty stays 1 until the synchronised wr_ptr_gray differs from 0000.
